// File: rtl/mem_responder.sv
// Single-port word memory behind a request/ready handshake with a fixed response latency.
// Misaligned or out-of-range accesses complete with Err and never touch the array.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic NoWait = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          acc_we;
    logic [31:0]   acc_adr;
    logic          acc_fault;
    logic [AW-1:0] acc_idx;
    logic          fault_q;
    logic          mem_we;

    assign accept = (state_q == StIdle) && Req;

    // With no wait cycles the read happens on the accepting edge, so use the live inputs then.
    assign acc_we    = accept ? MemWrite : we_q;
    assign acc_adr   = accept ? Adr : adr_q;
    assign acc_fault = (|acc_adr[1:0]) || (|acc_adr[31:AW+2]);
    assign acc_idx   = acc_adr[AW+1:2];

    assign fault_q = (|adr_q[1:0]) || (|adr_q[31:AW+2]);
    assign mem_we  = (state_q == StResp) && we_q && !fault_q && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (accept) begin
                we_q    <= MemWrite;
                adr_q   <= Adr;
                wdata_q <= WriteData;
            end
        end
    end

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[adr_q[AW+1:2]] <= wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (Req) begin
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = NoWait ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Read data is captured on the edge entering RESP so it is registered during the Ready cycle.
    always_comb begin
        rdata_d = rdata_q;
        if ((state_d == StResp) && (state_q != StResp)) begin
            if (acc_fault) begin
                rdata_d = '0;
            end else if (!acc_we) begin
                rdata_d = mem[acc_idx];
            end
        end
    end

    always_comb begin
        Ready    = (state_q == StResp);
        Err      = (state_q == StResp) && fault_q;
        ReadData = rdata_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (64 words / 2 wait cycles, 16 words / no wait),
// directed vector table, hand-written multi-cycle sequences and randomized accesses vs a model.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        req [2];
    logic        mw  [2];
    logic [31:0] adr [2];
    logic [31:0] wd  [2];
    logic [31:0] rd  [2];
    logic        rdy [2];
    logic        err [2];

    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .reset(rst[0]), .Req(req[0]), .MemWrite(mw[0]), .Adr(adr[0]),
        .WriteData(wd[0]), .ReadData(rd[0]), .Ready(rdy[0]), .Err(err[0])
    );

    mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset(rst[1]), .Req(req[1]), .MemWrite(mw[1]), .Adr(adr[1]),
        .WriteData(wd[1]), .ReadData(rd[1]), .Ready(rdy[1]), .Err(err[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mdl [2][64];
    logic [31:0] last_rd [2];

    typedef struct packed {
        logic        u;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic        ee;
        logic [31:0] er;
    } vec_t;

    vec_t tbl [16];

    function automatic int depth_of(input int u);
        return (u == 0) ? 64 : 16;
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    endtask

    // Reference behaviour straight from the access rules: fault, write, or read.
    function automatic void model_apply(input int u, input bit we, input logic [31:0] a,
                                        input logic [31:0] d, output bit ee,
                                        output logic [31:0] er);
        int unsigned lim;
        int unsigned idx;
        lim = 4 * depth_of(u);
        idx = a >> 2;
        if ((a % 4 != 0) || (a >= lim)) begin
            ee = 1'b1;
            er = '0;
            last_rd[u] = '0;
        end else if (we) begin
            mdl[u][idx] = d;
            ee = 1'b0;
            er = last_rd[u];
        end else begin
            ee = 1'b0;
            er = mdl[u][idx];
            last_rd[u] = er;
        end
    endfunction

    // Starts at a negedge with the unit idle; returns at a negedge with the unit idle again.
    task automatic do_access(input int u, input bit we, input logic [31:0] a,
                             input logic [31:0] d, output bit e, output logic [31:0] r);
        int  n;
        bit  seen;
        bit  spurious;
        seen = 1'b0;
        spurious = 1'b0;
        n = 99;
        e = 1'b0;
        r = '0;
        req[u] = 1'b1;
        mw[u]  = we;
        adr[u] = a;
        wd[u]  = d;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req[u] = 1'b0;
                mw[u]  = 1'($urandom);
                adr[u] = $urandom;
                wd[u]  = $urandom;
            end
            if (rdy[u]) begin
                seen = 1'b1;
                n = i;
                e = err[u];
                r = rd[u];
            end else if (err[u]) begin
                spurious = 1'b1;
            end
        end
        check($sformatf("latency u%0d adr %08h", u, a), 32'(n), 32'(lat_of(u) + 1));
        check($sformatf("err without ready u%0d", u), 32'(spurious), 32'd0);
        @(negedge clk);
        check($sformatf("ready one-cycle u%0d", u), 32'(rdy[u]), 32'd0);
        check($sformatf("readdata held u%0d", u), rd[u], r);
    endtask

    task automatic access_chk(input int u, input bit we, input logic [31:0] a,
                              input logic [31:0] d);
        bit          e, ee;
        logic [31:0] r, er;
        do_access(u, we, a, d, e, r);
        model_apply(u, we, a, d, ee, er);
        check($sformatf("err u%0d %s %08h", u, we ? "wr" : "rd", a), 32'(e), 32'(ee));
        check($sformatf("rdata u%0d %s %08h", u, we ? "wr" : "rd", a), r, er);
    endtask

    // Req held high: one completion per period, alternating reads of words 0 and 1.
    task automatic busy_run(input int u, input int samples, input int period);
        int k;
        k = 0;
        req[u] = 1'b1;
        mw[u]  = 1'b0;
        adr[u] = 32'h0;
        for (int i = 1; i <= samples; i++) begin
            @(negedge clk);
            if (rdy[u]) begin
                check($sformatf("busy u%0d ready %0d cycle", u, k), 32'(i),
                      32'(lat_of(u) + 1 + k * period));
                check($sformatf("busy u%0d ready %0d data", u, k), rd[u], mdl[u][k % 2]);
                check($sformatf("busy u%0d ready %0d err", u, k), 32'(err[u]), 32'd0);
                k++;
            end
            adr[u] = ((i / period) % 2 != 0) ? 32'h4 : 32'h0;
            if (i == samples) req[u] = 1'b0;
        end
        check($sformatf("busy u%0d ready count", u), 32'(k), 32'(samples / period));
        if (k > 0) last_rd[u] = mdl[u][(k - 1) % 2];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          e;
        logic [31:0] r;
        int          nrdy;

        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1;
            req[u] = 1'b0;
            mw[u]  = 1'b0;
            adr[u] = '0;
            wd[u]  = '0;
            last_rd[u] = '0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("reset ready u%0d", u), 32'(rdy[u]), 32'd0);
            check($sformatf("reset err u%0d", u), 32'(err[u]), 32'd0);
            check($sformatf("reset readdata u%0d", u), rd[u], 32'd0);
            rst[u] = 1'b0;
        end
        @(negedge clk);

        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < depth_of(u); i++) begin
                access_chk(u, 1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i));
            end
        end

        tbl[0]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,          1'b0, 32'hA500_0000};
        tbl[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF,  1'b0, 32'hA500_0000};
        tbl[2]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          1'b0, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b0, 1'b0, 32'h0000_0013, 32'h0,          1'b1, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 32'h0000_0013, 32'h1,          1'b1, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          1'b0, 32'hDEAD_BEEF};
        tbl[6]  = '{1'b0, 1'b1, 32'h0000_0100, 32'h55,         1'b1, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0000_00FC, 32'h0,          1'b0, 32'hA500_003F};
        tbl[8]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,          1'b0, 32'hA500_0000};
        tbl[9]  = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,          1'b1, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 32'h0000_003C, 32'h0,          1'b0, 32'hA500_000F};
        tbl[11] = '{1'b1, 1'b1, 32'h0000_0040, 32'h77,         1'b1, 32'h0};
        tbl[12] = '{1'b1, 1'b1, 32'h0000_0002, 32'h77,         1'b1, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          1'b0, 32'hA500_0000};
        tbl[14] = '{1'b1, 1'b1, 32'h0000_0004, 32'h1234_5678,  1'b0, 32'hA500_0000};
        tbl[15] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,          1'b0, 32'h1234_5678};

        for (int t = 0; t < 16; t++) begin
            bit          ee;
            logic [31:0] er;
            do_access(int'(tbl[t].u), tbl[t].we, tbl[t].a, tbl[t].d, e, r);
            model_apply(int'(tbl[t].u), tbl[t].we, tbl[t].a, tbl[t].d, ee, er);
            check($sformatf("vec %0d err", t), 32'(e), 32'(tbl[t].ee));
            check($sformatf("vec %0d rdata", t), r, tbl[t].er);
        end

        busy_run(0, 16, 4);
        busy_run(1, 8, 2);

        // Reset lands in WAIT of a write; a second reset edge also carries a request.
        req[0] = 1'b1;
        mw[0]  = 1'b1;
        adr[0] = 32'h20;
        wd[0]  = 32'hCAFE_F00D;
        @(negedge clk);
        check("abort ready in wait", 32'(rdy[0]), 32'd0);
        rst[0] = 1'b1;
        wd[0]  = 32'h1234_5678;
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        req[0] = 1'b0;
        nrdy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rdy[0]) nrdy++;
        end
        check("abort ready count", 32'(nrdy), 32'd0);
        check("abort readdata cleared", rd[0], 32'd0);
        last_rd[0] = '0;
        access_chk(0, 1'b0, 32'h20, 32'h0);

        for (int it = 0; it < 150; it++) begin
            int          u;
            int unsigned lim;
            int          sel;
            logic [31:0] a;
            u   = int'($urandom_range(0, 1));
            lim = 4 * depth_of(u);
            repeat ($urandom_range(0, 2)) begin
                adr[u] = $urandom;
                wd[u]  = $urandom;
                mw[u]  = 1'($urandom);
                @(negedge clk);
            end
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                a = 32'($urandom_range(0, depth_of(u) - 1) * 4 + $urandom_range(1, 3));
            end else if (sel == 1) begin
                a = $urandom;
                if (a < lim) a = a + lim;
            end else begin
                a = 32'($urandom_range(0, depth_of(u) - 1) * 4);
            end
            access_chk(u, 1'($urandom), a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, default 64, number of 32-bit words stored (power of two, 4..4096).
REQ-002 Parameter: WAIT_CYCLES, default 2, extra cycles between request acceptance and response (0..15).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 Req  input  1  processor access request; sampled only in IDLE.
REQ-007 MemWrite  input  1  1 = write access, 0 = read access; sampled with Req.
REQ-008 Adr  input  32  byte address; sampled with Req.
REQ-009 WriteData  input  32  store data; sampled with Req.
REQ-010 ReadData  output  32  load data; valid when Ready=1, held until next response.
REQ-011 Ready  output  1  one-cycle pulse marking access completion.
REQ-012 Err  output  1  one-cycle pulse, coincident with Ready, marking a faulted access.

Function
REQ-013 FSM states: IDLE, WAIT, RESP; encoding left to implementer.
REQ-014 IDLE, Req=1: latch MemWrite, Adr, WriteData; load wait counter with WAIT_CYCLES; go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-015 IDLE, Req=0: remain in IDLE; no state or memory change.
REQ-016 WAIT: decrement counter each cycle; go to RESP on the cycle the counter reaches 1 -> total WAIT occupancy exactly WAIT_CYCLES cycles.
REQ-017 RESP: Ready=1 for exactly one cycle; perform the latched access; return to IDLE next cycle.
REQ-018 Latency: Req accepted at edge N -> Ready high during cycle N+1+WAIT_CYCLES.
REQ-019 Req is ignored in WAIT and RESP; no queuing; a new request is accepted no earlier than the cycle after RESP.
REQ-020 Word index = latched Adr[log2(DEPTH_WORDS)+1:2].
REQ-021 Fault: latched Adr[1:0] != 0 (misaligned) or latched Adr >= 4*DEPTH_WORDS (out of range).
REQ-022 Faulted access: Err=1 with Ready; no memory write; ReadData driven to 0.
REQ-023 Valid write: word updated at the RESP edge; ReadData unchanged.
REQ-024 Valid read: ReadData = addressed word, registered and visible during RESP cycle.
REQ-025 Read following a write to the same word returns the newly written value.
REQ-026 Ready=0 and Err=0 in IDLE and WAIT.
REQ-027 Changes on Adr/WriteData/MemWrite after acceptance have no effect on the in-flight access.

Reset
REQ-028 reset=1 at any edge: FSM to IDLE, wait counter 0, Ready=0, Err=0, ReadData=0.
REQ-029 Reset during WAIT or RESP aborts the access; a write not yet at its RESP edge is not performed.
REQ-030 Memory array contents are not cleared by reset.
REQ-031 Reset has priority over Req on the same edge.

Verification
REQ-032 Write/read, WAIT_CYCLES=2: write 0xDEADBEEF to Adr 0x10, then read 0x10 -> Ready 3 cycles after each acceptance, ReadData=0xDEADBEEF, Err=0.
REQ-033 Misaligned: read Adr 0x13 -> Ready=1, Err=1, ReadData=0; write 0x1 to 0x13 -> Err=1, word 0x10 still 0xDEADBEEF.
REQ-034 Out of range, DEPTH_WORDS=64: write 0x55 to Adr 0x100 -> Err=1; read 0x0FC -> Err=0, last word readable.
REQ-035 Busy ignore: hold Req=1 continuously with reads to 0x0,0x4 -> exactly one Ready per 4 cycles (IDLE+2 WAIT+RESP), Ready never back-to-back.
REQ-036 Reset mid-write: write 0xCAFEF00D to 0x20, assert reset in WAIT -> Ready never pulses; subsequent read of 0x20 returns prior contents.
REQ-037 WAIT_CYCLES=0: read accepted at edge N -> Ready during cycle N+1; back-to-back reads complete every 2 cycles.
